// File: rtl/fmrv32im_axi_uart_tx.sv
// AXI4-Lite UART transmitter: byte FIFO fed over the bus, drained as 8N1 frames on UART_TXD.
// Registers: TXDATA (push), STATUS (busy/full/empty/ovf/count), BAUD_DIV (clocks per bit).
module fmrv32im_axi_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 417
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] S_AXI_AWADDR,
  input  logic [3:0]  S_AXI_AWCACHE,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [15:0] S_AXI_ARADDR,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        UART_TXD
);

  // state | meaning
  // IDLE  | line high, waiting for a byte in the FIFO
  // START | start bit (0) for div clocks
  // DATA  | 8 data bits LSB first, div clocks each
  // STOP  | stop bit (1) for div clocks, then next byte or IDLE
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic        awready, bvalid, arready, rvalid;
  logic [31:0] rdata, rd_mux, status;
  logic        wr_fire, rd_fire, push_req, push, pop;
  logic [15:0] baud, div_eff;
  logic        ovf;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [8:0]  count_ext;
  logic        full, empty;

  state_t      state, state_d;
  logic [7:0]  shift, shift_d;
  logic [15:0] div_q, div_d, cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic        txd, txd_d, tc;

  logic        unused_bits;
  assign unused_bits = ^{S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_ARCACHE, S_AXI_ARPROT,
                         S_AXI_AWADDR[15:4], S_AXI_AWADDR[1:0], S_AXI_ARADDR[15:4],
                         S_AXI_ARADDR[1:0], S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = awready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign UART_TXD      = txd;

  assign wr_fire  = awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire  = arready & S_AXI_ARVALID;
  assign push_req = wr_fire && (S_AXI_AWADDR[3:2] == 2'd0) && S_AXI_WSTRB[0];
  assign push     = push_req && !full;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign count_ext = 9'(count);
  assign status   = {19'b0, count_ext, ovf, empty, full, (state != IDLE)};
  assign div_eff  = (baud == 16'd0) ? 16'd1 : baud;

  always_comb begin
    case (S_AXI_ARADDR[3:2])
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {16'b0, baud};
      default: rd_mux = 32'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      awready <= 1'b0;
      bvalid  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'b0;
    end else begin
      awready <= !awready && !bvalid && S_AXI_AWVALID && S_AXI_WVALID;
      if (wr_fire)           bvalid <= 1'b1;
      else if (S_AXI_BREADY) bvalid <= 1'b0;
      arready <= !arready && !rvalid && S_AXI_ARVALID;
      if (rd_fire) begin
        rdata  <= rd_mux;
        rvalid <= 1'b1;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      baud <= 16'(DEFAULT_DIV);
      ovf  <= 1'b0;
    end else begin
      if (wr_fire && S_AXI_AWADDR[3:2] == 2'd2) begin
        if (S_AXI_WSTRB[0]) baud[7:0]  <= S_AXI_WDATA[7:0];
        if (S_AXI_WSTRB[1]) baud[15:8] <= S_AXI_WDATA[15:8];
      end
      if (push_req && full)
        ovf <= 1'b1;
      else if (wr_fire && S_AXI_AWADDR[3:2] == 2'd1 && S_AXI_WSTRB[0] && S_AXI_WDATA[3])
        ovf <= 1'b0;
    end
  end

  // Storage needs no reset; emptiness is carried entirely by the pointers/count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= S_AXI_WDATA[7:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign tc = (cnt == div_q - 16'd1);

  always_comb begin
    state_d = state;
    shift_d = shift;
    div_d   = div_q;
    cnt_d   = cnt;
    idx_d   = idx;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = mem[rd_ptr];
        div_d   = div_eff;
        cnt_d   = 16'd0;
        state_d = START;
      end
      START: if (tc) begin
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
        state_d = DATA;
      end else cnt_d = cnt + 16'd1;
      DATA: if (tc) begin
        cnt_d   = 16'd0;
        shift_d = {1'b0, shift[7:1]};
        idx_d   = idx + 3'd1;
        if (idx == 3'd7) state_d = STOP;
      end else cnt_d = cnt + 16'd1;
      STOP: if (tc) begin
        cnt_d = 16'd0;
        // Back-to-back frames: reload straight into START with no idle bit.
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          div_d   = div_eff;
          state_d = START;
        end else state_d = IDLE;
      end else cnt_d = cnt + 16'd1;
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      shift <= 8'd0;
      div_q <= 16'd1;
      cnt   <= 16'd0;
      idx   <= 3'd0;
      txd   <= 1'b1;
    end else begin
      state <= state_d;
      shift <= shift_d;
      div_q <= div_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      txd   <= txd_d;
    end
  end

endmodule

// File: tb/tb_fmrv32im_axi_uart_tx.sv
// Directed bench for the AXI UART transmitter: register access, frame shape and timing,
// FIFO full/overflow, write-response backpressure, divisor edge cases and async reset.
module tb_fmrv32im_axi_uart_tx;

  logic        CLK, RST_N;
  logic [15:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [3:0]  S_AXI_AWCACHE, S_AXI_ARCACHE, S_AXI_WSTRB;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY, UART_TXD;

  int          n_vec = 0;
  int          n_err = 0;
  int          n;
  logic [31:0] rd;

  fmrv32im_axi_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_DIV(417)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARCACHE(S_AXI_ARCACHE),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .UART_TXD(UART_TXD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int k;
    @(negedge CLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    k = 0;
    while (!S_AXI_AWREADY && k < 50) begin @(negedge CLK); k++; end
    if (!S_AXI_AWREADY) chk("awready_timeout", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge CLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] addr, output logic [31:0] data);
    int k;
    @(negedge CLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    k = 0;
    while (!S_AXI_ARREADY && k < 50) begin @(negedge CLK); k++; end
    if (!S_AXI_ARREADY) chk("arready_timeout", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge CLK); #1;
    S_AXI_ARVALID = 1'b0;
    @(negedge CLK);
    k = 0;
    while (!S_AXI_RVALID && k < 50) begin @(negedge CLK); k++; end
    if (!S_AXI_RVALID) chk("rvalid_timeout", 32'(S_AXI_RVALID), 32'd1);
    data = S_AXI_RDATA;
  endtask

  // Samples TXD once per clock for a whole 8N1 frame; the next negedge must follow the start edge.
  task automatic check_frame(input string tag, input logic [7:0] b, input int div);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * div; k++) begin
      @(negedge CLK);
      chk(tag, 32'(UART_TXD), 32'(fr[k / div]));
    end
  endtask

  initial begin
    RST_N = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWCACHE = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARCACHE = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_txd", 32'(UART_TXD), 32'd1);
    chk("rst_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
    chk("rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    axi_read(16'h8, rd);  chk("rst_baud", rd, 32'h0000_01A1);
    axi_read(16'h4, rd);  chk("rst_status", rd, 32'h0000_0004);
    chk("idle_txd", 32'(UART_TXD), 32'd1);

    axi_write(16'hC, 32'hFFFF_FFFF, 4'hF);
    @(negedge CLK);
    chk("bvalid_after_wr", 32'(S_AXI_BVALID), 32'd1);
    chk("bresp", 32'(S_AXI_BRESP), 32'd0);
    axi_read(16'h8, rd);  chk("rsvd_wr_baud", rd, 32'h0000_01A1);
    axi_read(16'hC, rd);  chk("rsvd_rd", rd, 32'd0);
    axi_read(16'h0, rd);  chk("txdata_rd", rd, 32'd0);

    axi_write(16'h8, 32'h0000_ABCD, 4'b0001);
    axi_read(16'h8, rd);  chk("baud_strb0", rd, 32'h0000_01CD);
    axi_write(16'h8, 32'h0000_1200, 4'b0010);
    axi_read(16'h8, rd);  chk("baud_strb1", rd, 32'h0000_12CD);
    axi_write(16'h0, 32'h0000_0055, 4'b0010);
    axi_read(16'h4, rd);  chk("txdata_nostrb", rd, 32'h0000_0004);

    // Write response held off: second AW/W must wait, reads keep working.
    @(negedge CLK);
    S_AXI_AWADDR = 16'h8; S_AXI_WDATA = 32'd5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge CLK); n++; end
    chk("hold_wready", 32'(S_AXI_WREADY), 32'd1);
    @(posedge CLK); #1;
    S_AXI_WDATA = 32'd7;
    axi_read(16'h8, rd);  chk("hold_rd", rd, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("hold_bvalid", 32'(S_AXI_BVALID), 32'd1);
      chk("hold_awready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge CLK); n++; end
    chk("second_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge CLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    axi_read(16'h8, rd);  chk("second_wr", rd, 32'd7);

    // Single frame 0x55 at 4 clocks/bit.
    axi_write(16'h8, 32'd4, 4'hF);
    axi_write(16'h0, 32'h55, 4'h1);
    @(negedge CLK);
    chk("pre_start_55", 32'(UART_TXD), 32'd1);
    check_frame("frame_55", 8'h55, 4);
    axi_read(16'h4, rd);  chk("post_55_status", rd, 32'h0000_0004);

    // Two gap-free frames at 2 clocks/bit.
    axi_write(16'h8, 32'd2, 4'hF);
    axi_write(16'h0, 32'h0F, 4'h1);
    @(negedge CLK);
    chk("pre_start_gap", 32'(UART_TXD), 32'd1);
    fork
      begin
        check_frame("gap_0f", 8'h0F, 2);
        check_frame("gap_f0", 8'hF0, 2);
      end
      axi_write(16'h0, 32'hF0, 4'h1);
    join
    @(negedge CLK);
    chk("post_gap_txd", 32'(UART_TXD), 32'd1);
    axi_read(16'h4, rd);  chk("post_gap_status", rd, 32'h0000_0004);

    // Fill FIFO under a slow divisor: 17 writes, first one is popped at once.
    axi_write(16'h8, 32'd50, 4'hF);
    for (int i = 0; i < 17; i++) axi_write(16'h0, 32'(8'h30 + i), 4'h1);
    axi_read(16'h4, rd);  chk("fill_status", rd, 32'h0000_0103);
    axi_write(16'h0, 32'hEE, 4'h1);
    axi_read(16'h4, rd);  chk("ovf_status", rd, 32'h0000_010B);
    axi_write(16'h4, 32'h8, 4'h1);
    axi_read(16'h4, rd);  chk("ovf_clear", rd, 32'h0000_0103);
    axi_write(16'h8, 32'd2, 4'hF);
    n = 0;
    do begin
      axi_read(16'h4, rd);
      n++;
    end while (rd != 32'h4 && n < 500);
    chk("drain_status", rd, 32'h0000_0004);

    // Divisor 0 behaves as 1; a mid-frame divisor write waits for the next frame.
    axi_write(16'h8, 32'd0, 4'hF);
    axi_read(16'h8, rd);  chk("baud_zero_rd", rd, 32'd0);
    axi_write(16'h0, 32'hA0, 4'h1);
    @(negedge CLK);
    chk("pre_start_a0", 32'(UART_TXD), 32'd1);
    fork
      check_frame("frame_a0_div1", 8'hA0, 1);
      axi_write(16'h8, 32'd8, 4'hF);
    join
    axi_read(16'h8, rd);  chk("baud_8_rd", rd, 32'd8);
    axi_write(16'h0, 32'h3C, 4'h1);
    @(negedge CLK);
    chk("pre_start_3c", 32'(UART_TXD), 32'd1);
    check_frame("frame_3c_div8", 8'h3C, 8);

    // Reset in the middle of DATA with one byte still queued.
    axi_write(16'h8, 32'd4, 4'hF);
    axi_write(16'h0, 32'h00, 4'h1);
    axi_write(16'h0, 32'h00, 4'h1);
    repeat (6) @(negedge CLK);
    chk("mid_data_txd", 32'(UART_TXD), 32'd0);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_txd", 32'(UART_TXD), 32'd1);
    chk("async_rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_ARREADY}), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    axi_read(16'h4, rd);  chk("post_rst_status", rd, 32'h0000_0004);
    axi_read(16'h8, rd);  chk("post_rst_baud", rd, 32'h0000_01A1);
    chk("post_rst_txd", 32'(UART_TXD), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
